// File: rtl/mem_bus_arbiter_if.sv
// ============================================================================
// mem_bus_arbiter_if
// ----------------------------------------------------------------------------
// Purpose : bundles the two upstream requester channels (fetch, mem-stage) and
//           the downstream load/store-unit channel of the memory bus arbiter.
//
// Signals :
//   fetch    : if_req, if_addr          -> arbiter ; if_done, if_rdata  <- arbiter
//   mem      : mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb -> arbiter
//              mem_done, mem_rdata      <- arbiter
//   bus      : bus_valid, bus_we, bus_addr, bus_wdata, bus_wstrb <- arbiter
//              bus_done, bus_rdata      -> arbiter
//
// Modports:
//   master : the arbiter's view (it masters the downstream bus and answers
//            both requesters).
//   slave  : the environment's view (requesters plus the downstream unit).
// ============================================================================
interface mem_bus_arbiter_if;
    // fetch requester
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_rdata;
    // mem-stage requester
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_done;
    logic [31:0] mem_rdata;
    // downstream load/store unit
    logic        bus_valid;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_done;
    logic [31:0] bus_rdata;

    modport master (
        input  if_req, if_addr,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  bus_done, bus_rdata,
        output if_done, if_rdata, mem_done, mem_rdata,
        output bus_valid, bus_we, bus_addr, bus_wdata, bus_wstrb
    );

    modport slave (
        output if_req, if_addr,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output bus_done, bus_rdata,
        input  if_done, if_rdata, mem_done, mem_rdata,
        input  bus_valid, bus_we, bus_addr, bus_wdata, bus_wstrb
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// ============================================================================
// mem_bus_arbiter
// ----------------------------------------------------------------------------
// Purpose : shares the single data-memory bus between the instruction-fetch
//           requester (read-only) and the memory-stage requester (read/write).
//           Fixed priority (MEM_PRIO) with a bounded-starvation override: once
//           the non-base requester has lost MAX_WAIT contested grants it is
//           forced to win the next contest. One transaction in flight.
//
// Handshake:
//   Requesters raise x_req with a stable payload and hold both until x_done
//   (a one-cycle pulse, x_rdata valid in that cycle). Downstream, bus_valid is
//   a one-cycle issue pulse with bus_* held stable until the one-cycle
//   bus_done pulse that carries bus_rdata. bus_done outside WAIT is ignored.
//
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   mb           : mem_bus_arbiter_if.master (requester + downstream channels)
//   dbg_state    : current FSM state (0 IDLE, 1 ISSUE, 2 WAIT)
//   dbg_wait_cnt : current starvation counter
// ============================================================================
module mem_bus_arbiter #(
    parameter int MAX_WAIT = 4,
    parameter bit MEM_PRIO = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    mem_bus_arbiter_if.master         mb,
    output logic [1:0]                dbg_state,
    output logic [3:0]                dbg_wait_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

    state_t     state;
    logic       gnt_mem;    // 1: mem-stage owns the bus, 0: fetch owns it
    logic [3:0] wait_cnt;
    // A requester is masked only during the cycle its done pulse is out, so
    // a held request cannot be re-granted before the requester saw the done.
    logic       last_if;
    logic       last_mem;

    logic elig_if;
    logic elig_mem;
    logic both_elig;
    logic pick_mem;

    assign elig_if   = mb.if_req  & ~last_if;
    assign elig_mem  = mb.mem_req & ~last_mem;
    assign both_elig = elig_if & elig_mem;

    always_comb begin
        pick_mem = elig_mem;
        if (both_elig) begin
            // The starved (non-base) requester wins once wait_cnt is full.
            pick_mem = (wait_cnt == MAX_W) ? ~MEM_PRIO : MEM_PRIO;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            gnt_mem      <= 1'b0;
            wait_cnt     <= 4'd0;
            last_if      <= 1'b0;
            last_mem     <= 1'b0;
            mb.if_done   <= 1'b0;
            mb.if_rdata  <= 32'd0;
            mb.mem_done  <= 1'b0;
            mb.mem_rdata <= 32'd0;
            mb.bus_valid <= 1'b0;
            mb.bus_we    <= 1'b0;
            mb.bus_addr  <= 32'd0;
            mb.bus_wdata <= 32'd0;
            mb.bus_wstrb <= 4'd0;
        end else begin
            mb.if_done  <= 1'b0;
            mb.mem_done <= 1'b0;
            last_if     <= 1'b0;
            last_mem    <= 1'b0;

            case (state)
                IDLE: begin
                    if (elig_if || elig_mem) begin
                        gnt_mem <= pick_mem;
                        if (pick_mem) begin
                            mb.bus_we    <= mb.mem_we;
                            mb.bus_addr  <= mb.mem_addr;
                            mb.bus_wdata <= mb.mem_wdata;
                            mb.bus_wstrb <= mb.mem_wstrb;
                        end else begin
                            mb.bus_we    <= 1'b0;
                            mb.bus_addr  <= mb.if_addr;
                            mb.bus_wdata <= 32'd0;
                            mb.bus_wstrb <= 4'd0;
                        end

                        if (pick_mem != MEM_PRIO) begin
                            wait_cnt <= 4'd0;
                        end else if (both_elig && (wait_cnt != MAX_W)) begin
                            wait_cnt <= wait_cnt + 4'd1;
                        end

                        mb.bus_valid <= 1'b1;
                        state        <= ISSUE;
                    end
                end

                ISSUE: begin
                    mb.bus_valid <= 1'b0;
                    state        <= WAIT;
                end

                WAIT: begin
                    if (mb.bus_done) begin
                        if (gnt_mem) begin
                            mb.mem_done  <= 1'b1;
                            mb.mem_rdata <= mb.bus_we ? 32'd0 : mb.bus_rdata;
                            last_mem     <= 1'b1;
                        end else begin
                            mb.if_done   <= 1'b1;
                            mb.if_rdata  <= mb.bus_rdata;
                            last_if      <= 1'b1;
                        end
                        state <= IDLE;
                    end
                end

                default: begin
                    mb.bus_valid <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

    assign dbg_state    = state;
    assign dbg_wait_cnt = wait_cnt;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// ============================================================================
// tb_mem_bus_arbiter
// ----------------------------------------------------------------------------
// Directed bench for mem_bus_arbiter (MAX_WAIT=2, MEM_PRIO=1). Inputs are
// driven and outputs sampled on the falling edge; the DUT acts on the rising
// edge. Expected bus issues and read data are queued when a request is
// driven and popped by a monitor when the DUT issues or completes.
// ============================================================================
module tb_mem_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] dbg_state;
    logic [3:0] dbg_wait_cnt;

    mem_bus_arbiter_if mb();

    mem_bus_arbiter #(
        .MAX_WAIT (2),
        .MEM_PRIO (1'b1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mb           (mb),
        .dbg_state    (dbg_state),
        .dbg_wait_cnt (dbg_wait_cnt)
    );

    // ------------------------------------------------------------ clock/reset
    always #5 clk = ~clk;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    int checks = 0;
    int errors = 0;

    // record: {who_mem, we, addr[31:0], wdata[31:0], wstrb[3:0]}
    logic [69:0] exp_bus_q[$];
    logic [31:0] exp_if_q[$];
    logic [31:0] exp_mem_q[$];

    logic in_flight_if  = 1'b0;
    logic in_flight_mem = 1'b0;

    // ------------------------------------------------------------ helpers
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [69:0] mk_rec(input logic who_mem, input logic we,
                                           input logic [31:0] addr, input logic [31:0] wdata,
                                           input logic [3:0] wstrb);
        return {who_mem, we, addr, wdata, wstrb};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    // Wait (bounded) for the issue pulse, then answer with bus_done in the
    // first WAIT cycle. Returns on the falling edge of the done-pulse cycle.
    task automatic serve(input logic [31:0] rdata);
        int n;
        n = 0;
        while (!mb.bus_valid && n < 20) begin
            tick();
            n++;
        end
        if (!mb.bus_valid) begin
            checks++;
            errors++;
            $error("FAIL serve_timeout: observed no bus_valid expected bus_valid within 20 cycles");
        end else begin
            tick();
            mb.bus_done  = 1'b1;
            mb.bus_rdata = rdata;
            tick();
            mb.bus_done  = 1'b0;
            mb.bus_rdata = 32'd0;
        end
    endtask

    // ------------------------------------------------------------ scoreboard
    always @(negedge clk) begin : monitor
        logic [69:0] e;
        if (rst) begin
            in_flight_if  = 1'b0;
            in_flight_mem = 1'b0;
        end else begin
            if (mb.bus_valid) begin
                if (exp_bus_q.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL bus_unexpected: observed issue addr %h expected no issue", mb.bus_addr);
                end else begin
                    e = exp_bus_q.pop_front();
                    chk("bus_we",    32'(mb.bus_we),    32'(e[68]));
                    chk("bus_addr",  mb.bus_addr,       e[67:36]);
                    chk("bus_wdata", mb.bus_wdata,      e[35:4]);
                    chk("bus_wstrb", 32'(mb.bus_wstrb), 32'(e[3:0]));
                    if (e[69]) in_flight_mem = 1'b1;
                    else       in_flight_if  = 1'b1;
                end
            end
            if (mb.if_done) begin
                in_flight_if = 1'b0;
                if (exp_if_q.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL if_done_unexpected: observed if_done rdata %h expected none", mb.if_rdata);
                end else begin
                    chk("if_rdata", mb.if_rdata, exp_if_q.pop_front());
                end
            end
            if (mb.mem_done) begin
                in_flight_mem = 1'b0;
                if (exp_mem_q.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL mem_done_unexpected: observed mem_done rdata %h expected none", mb.mem_rdata);
                end else begin
                    chk("mem_rdata", mb.mem_rdata, exp_mem_q.pop_front());
                end
            end
        end
    end

    // A granted requester must keep its request up until its done pulse.
    always @(posedge clk) begin
        if (!rst) begin
            if (in_flight_if && !mb.if_req) begin
                checks++;
                errors++;
                $error("FAIL if_req_dropped: observed if_req 0 expected 1 while granted");
            end
            if (in_flight_mem && !mb.mem_req) begin
                checks++;
                errors++;
                $error("FAIL mem_req_dropped: observed mem_req 0 expected 1 while granted");
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: observed no finish expected finish before 200000 time units");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------ stimulus
    initial begin : stim
        mb.if_req    = 1'b0;
        mb.if_addr   = 32'd0;
        mb.mem_req   = 1'b0;
        mb.mem_we    = 1'b0;
        mb.mem_addr  = 32'd0;
        mb.mem_wdata = 32'd0;
        mb.mem_wstrb = 4'd0;
        mb.bus_done  = 1'b0;
        mb.bus_rdata = 32'd0;

        // ---- reset state
        tick();
        tick();
        chk("rst_state",     32'(dbg_state),    32'(S_IDLE));
        chk("rst_wait_cnt",  32'(dbg_wait_cnt), 32'd0);
        chk("rst_bus_valid", 32'(mb.bus_valid), 32'd0);
        chk("rst_bus_addr",  mb.bus_addr,       32'd0);
        chk("rst_if_done",   32'(mb.if_done),   32'd0);
        chk("rst_mem_rdata", mb.mem_rdata,      32'd0);
        rst = 1'b0;
        tick();

        // ---- fetch-only read: req at cycle 0, done at cycle 3
        mb.if_req  = 1'b1;
        mb.if_addr = 32'h0000_0100;
        exp_bus_q.push_back(mk_rec(1'b0, 1'b0, 32'h0000_0100, 32'd0, 4'd0));
        exp_if_q.push_back(32'hDEAD_BEEF);
        tick();                                                  // cycle 1
        chk("fo_bus_valid_c1", 32'(mb.bus_valid), 32'd1);
        chk("fo_state_c1",     32'(dbg_state),    32'(S_ISSUE));
        tick();                                                  // cycle 2
        chk("fo_bus_valid_c2", 32'(mb.bus_valid), 32'd0);
        chk("fo_state_c2",     32'(dbg_state),    32'(S_WAIT));
        tick();                                                  // cycle 3
        mb.bus_done  = 1'b1;
        mb.bus_rdata = 32'hDEAD_BEEF;
        tick();                                                  // cycle 4
        mb.bus_done  = 1'b0;
        mb.bus_rdata = 32'd0;
        chk("fo_if_done_c4",  32'(mb.if_done),  32'd1);
        chk("fo_mem_done_c4", 32'(mb.mem_done), 32'd0);
        mb.if_req = 1'b0;
        tick();                                                  // cycle 5
        chk("fo_if_done_c5",   32'(mb.if_done), 32'd0);
        chk("fo_if_rdata_hold", mb.if_rdata,    32'hDEAD_BEEF);
        chk("fo_state_c5",     32'(dbg_state),  32'(S_IDLE));

        // ---- mem store: bus mirrors payload, mem_rdata reads 0
        mb.mem_req   = 1'b1;
        mb.mem_we    = 1'b1;
        mb.mem_addr  = 32'h0000_0204;
        mb.mem_wdata = 32'h0000_AB00;
        mb.mem_wstrb = 4'b0010;
        exp_bus_q.push_back(mk_rec(1'b1, 1'b1, 32'h0000_0204, 32'h0000_AB00, 4'b0010));
        exp_mem_q.push_back(32'd0);
        serve(32'h1234_5678);
        chk("st_mem_done", 32'(mb.mem_done), 32'd1);
        chk("st_if_done",  32'(mb.if_done),  32'd0);
        mb.mem_req = 1'b0;
        mb.mem_we  = 1'b0;
        tick();

        // ---- tie: mem wins first, fetch granted in the mem_done cycle
        mb.if_req    = 1'b1;
        mb.if_addr   = 32'h0000_0300;
        mb.mem_req   = 1'b1;
        mb.mem_addr  = 32'h0000_0400;
        mb.mem_wdata = 32'h0000_0055;
        mb.mem_wstrb = 4'd0;
        exp_bus_q.push_back(mk_rec(1'b1, 1'b0, 32'h0000_0400, 32'h0000_0055, 4'd0));
        exp_bus_q.push_back(mk_rec(1'b0, 1'b0, 32'h0000_0300, 32'd0, 4'd0));
        exp_mem_q.push_back(32'h0000_00A1);
        exp_if_q.push_back(32'h0000_00B2);
        tick();
        chk("tie_bus_addr_mem", mb.bus_addr,        32'h0000_0400);
        chk("tie_wait_cnt_1",   32'(dbg_wait_cnt),  32'd1);
        serve(32'h0000_00A1);
        chk("tie_mem_done",   32'(mb.mem_done), 32'd1);
        chk("tie_state_done", 32'(dbg_state),   32'(S_IDLE));
        mb.mem_req = 1'b0;
        tick();
        chk("tie_fetch_valid", 32'(mb.bus_valid),  32'd1);
        chk("tie_fetch_addr",  mb.bus_addr,        32'h0000_0300);
        chk("tie_wait_cnt_0",  32'(dbg_wait_cnt),  32'd0);
        serve(32'h0000_00B2);
        chk("tie_if_done", 32'(mb.if_done), 32'd1);
        mb.if_req = 1'b0;

        // ---- starvation: fresh contests; fetch loses twice, wins the third.
        // Fetch withdraws after losing so the done-cycle mask does not hand
        // it the bus early; each contest is a genuine tie.
        for (int r = 0; r < 3; r++) begin
            tick();
            mb.if_req    = 1'b1;
            mb.if_addr   = 32'h0000_0500;
            mb.mem_req   = 1'b1;
            mb.mem_we    = 1'b0;
            mb.mem_addr  = 32'h0000_0600 + 32'(r * 4);
            mb.mem_wdata = 32'd0;
            mb.mem_wstrb = 4'd0;
            if (r < 2) begin
                exp_bus_q.push_back(mk_rec(1'b1, 1'b0, 32'h0000_0600 + 32'(r * 4), 32'd0, 4'd0));
                exp_mem_q.push_back(32'h0000_5A00 + 32'(r));
            end else begin
                exp_bus_q.push_back(mk_rec(1'b0, 1'b0, 32'h0000_0500, 32'd0, 4'd0));
                exp_if_q.push_back(32'h0000_5A00 + 32'(r));
            end
            tick();
            chk("stv_wait_cnt", 32'(dbg_wait_cnt), (r < 2) ? 32'(r + 1) : 32'd0);
            if (r < 2) begin
                mb.if_req = 1'b0;
                serve(32'h0000_5A00 + 32'(r));
                mb.mem_req = 1'b0;
            end else begin
                mb.mem_req = 1'b0;
                serve(32'h0000_5A00 + 32'(r));
                mb.if_req = 1'b0;
            end
        end

        // ---- spurious done in IDLE, early done in ISSUE
        tick();
        mb.bus_done  = 1'b1;
        mb.bus_rdata = 32'h0000_00FF;
        tick();
        mb.bus_done  = 1'b0;
        mb.bus_rdata = 32'd0;
        chk("sp_idle_if_done",  32'(mb.if_done),  32'd0);
        chk("sp_idle_mem_done", 32'(mb.mem_done), 32'd0);
        chk("sp_idle_state",    32'(dbg_state),   32'(S_IDLE));
        chk("sp_mem_rdata_hold", mb.mem_rdata,    32'h0000_5A01);
        mb.mem_req  = 1'b1;
        mb.mem_addr = 32'h0000_0700;
        exp_bus_q.push_back(mk_rec(1'b1, 1'b0, 32'h0000_0700, 32'd0, 4'd0));
        exp_mem_q.push_back(32'h0000_00C3);
        tick();                                                  // ISSUE
        mb.bus_done  = 1'b1;
        mb.bus_rdata = 32'h0000_0BAD;
        tick();                                                  // WAIT
        mb.bus_done  = 1'b0;
        mb.bus_rdata = 32'd0;
        chk("sp_issue_state",    32'(dbg_state),   32'(S_WAIT));
        chk("sp_issue_mem_done", 32'(mb.mem_done), 32'd0);
        tick();
        chk("sp_wait_hold", 32'(dbg_state), 32'(S_WAIT));
        mb.bus_done  = 1'b1;
        mb.bus_rdata = 32'h0000_00C3;
        tick();
        mb.bus_done  = 1'b0;
        mb.bus_rdata = 32'd0;
        chk("sp_mem_done", 32'(mb.mem_done), 32'd1);
        mb.mem_req = 1'b0;
        tick();

        // ---- back-to-back fetch: held req re-granted no earlier than K+2
        mb.if_req  = 1'b1;
        mb.if_addr = 32'h0000_0900;
        exp_bus_q.push_back(mk_rec(1'b0, 1'b0, 32'h0000_0900, 32'd0, 4'd0));
        exp_bus_q.push_back(mk_rec(1'b0, 1'b0, 32'h0000_0904, 32'd0, 4'd0));
        exp_if_q.push_back(32'h0000_0011);
        exp_if_q.push_back(32'h0000_0022);
        serve(32'h0000_0011);
        chk("b2b_if_done", 32'(mb.if_done), 32'd1);             // K+1
        mb.if_addr = 32'h0000_0904;
        tick();                                                  // K+2
        chk("b2b_state_k2", 32'(dbg_state),   32'(S_IDLE));
        chk("b2b_valid_k2", 32'(mb.bus_valid), 32'd0);
        tick();                                                  // K+3
        chk("b2b_valid_k3", 32'(mb.bus_valid), 32'd1);
        serve(32'h0000_0022);
        mb.if_req = 1'b0;
        tick();

        // ---- reset in WAIT abandons the transaction; pending req reissues
        mb.if_req  = 1'b1;
        mb.if_addr = 32'h0000_0800;
        exp_bus_q.push_back(mk_rec(1'b0, 1'b0, 32'h0000_0800, 32'd0, 4'd0));
        tick();
        tick();
        chk("rw_state_wait", 32'(dbg_state), 32'(S_WAIT));
        rst = 1'b1;
        #1;
        chk("rw_bus_valid", 32'(mb.bus_valid), 32'd0);
        chk("rw_bus_addr",  mb.bus_addr,       32'd0);
        chk("rw_if_done",   32'(mb.if_done),   32'd0);
        chk("rw_if_rdata",  mb.if_rdata,       32'd0);
        chk("rw_state",     32'(dbg_state),    32'(S_IDLE));
        tick();
        tick();
        rst = 1'b0;
        exp_bus_q.push_back(mk_rec(1'b0, 1'b0, 32'h0000_0800, 32'd0, 4'd0));
        exp_if_q.push_back(32'h0000_00E4);
        tick();
        chk("rw_reissue_valid", 32'(mb.bus_valid), 32'd1);
        serve(32'h0000_00E4);
        chk("rw_if_done_after", 32'(mb.if_done), 32'd1);
        mb.if_req = 1'b0;

        // ---- drain: every expected issue and completion must have appeared
        repeat (3) tick();
        chk("drain_bus_q", 32'(exp_bus_q.size()), 32'd0);
        chk("drain_if_q",  32'(exp_if_q.size()),  32'd0);
        chk("drain_mem_q", 32'(exp_mem_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
